// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer
//   Iterative HI/LO multiply/divide unit with its sequencing FSM. Accepts
//   MULT/MULTU/DIV/DIVU from execute and runs a WIDTH-step shift-add multiply
//   or restoring divide. It holds execute via stall_o until the result is
//   ready, then commits HI/LO. It also serves MTHI/MTLO writes. Flush aborts
//   an operation in flight.
//
//   Handshake: in IDLE, start_i high and flush_i low at a clock edge accepts
//   the op. stall_o is high in that same cycle and throughout CALC, and low in
//   DONE, so execute advances while done_o is high. start_i is ignored outside
//   IDLE.
//
// Ports
//   clk, reset         clock and synchronous active-high reset
//   start_i, op_i      op request (00 MULT, 01 MULTU, 10 DIV, 11 DIVU)
//   src_a_i, src_b_i   operands (multiplicand/dividend, multiplier/divisor)
//   flush_i            kill the op in execute
//   hi_we_i, lo_we_i   MTHI / MTLO write enables; wdata_i is the write data
//   stall_o            hold execute and earlier stages
//   done_o             one-cycle pulse when an op has just updated HI/LO
//   busy_o             FSM not IDLE
//   hi_o, lo_o         HI / LO registers
module muldiv_sequencer #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start_i,
    input  logic [1:0]       op_i,
    input  logic [WIDTH-1:0] src_a_i,
    input  logic [WIDTH-1:0] src_b_i,
    input  logic             flush_i,
    input  logic             hi_we_i,
    input  logic             lo_we_i,
    input  logic [WIDTH-1:0] wdata_i,
    output logic             stall_o,
    output logic             done_o,
    output logic             busy_o,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

    state_t               state_q;
    logic [CW-1:0]        cnt_q;
    logic [2*WIDTH-1:0]   acc_q;    // mul: {partial hi, multiplier}; div: {remainder, quotient}
    logic [2*WIDTH-1:0]   acc_d;
    logic [WIDTH-1:0]     opnd_q;   // |multiplicand| or |divisor|
    logic [WIDTH-1:0]     hi_q, lo_q, hi_d, lo_d;
    logic                 is_div_q, neg_q, sign_a_q, divz_q, done_q;

    // Operand conditioning at accept: signed ops work on magnitudes.
    logic                 sa, sb;
    logic [WIDTH-1:0]     abs_a, abs_b;

    always_comb begin
        sa    = ~op_i[0] & src_a_i[WIDTH-1];
        sb    = ~op_i[0] & src_b_i[WIDTH-1];
        abs_a = sa ? (~src_a_i + 1'b1) : src_a_i;
        abs_b = sb ? (~src_b_i + 1'b1) : src_b_i;
    end

    // One iteration of shift-add multiply or restoring divide.
    logic [WIDTH:0]       mul_sum, div_shift, div_diff;
    logic [2*WIDTH-1:0]   prod_fix;
    logic [WIDTH-1:0]     quo_fix, rem_fix;

    always_comb begin
        mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
        div_shift = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
        div_diff  = div_shift - {1'b0, opnd_q};
        if (is_div_q) begin
            // Top bit of the difference is the borrow: clear means rem >= divisor.
            if (!div_diff[WIDTH])
                acc_d = {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
            else
                acc_d = {div_shift[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
        end else begin
            acc_d = {mul_sum, acc_q[WIDTH-1:1]};
        end

        // Sign fixup applied to the final iteration's value.
        prod_fix = neg_q ? (~acc_d + 1'b1) : acc_d;
        quo_fix  = neg_q ? (~acc_d[WIDTH-1:0] + 1'b1) : acc_d[WIDTH-1:0];
        rem_fix  = sign_a_q ? (~acc_d[2*WIDTH-1:WIDTH] + 1'b1) : acc_d[2*WIDTH-1:WIDTH];

        if (is_div_q) begin
            // Divide by zero: the fixed-up remainder reproduces src_a, and the quotient is all ones.
            hi_d = rem_fix;
            lo_d = divz_q ? '1 : quo_fix;
        end else begin
            hi_d = prod_fix[2*WIDTH-1:WIDTH];
            lo_d = prod_fix[WIDTH-1:0];
        end
    end

    always_comb begin
        stall_o = 1'b0;
        if (!reset) begin
            case (state_q)
                S_IDLE:  stall_o = start_i & ~flush_i;
                S_CALC:  stall_o = 1'b1;
                default: stall_o = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            acc_q    <= '0;
            opnd_q   <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            is_div_q <= 1'b0;
            neg_q    <= 1'b0;
            sign_a_q <= 1'b0;
            divz_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (flush_i) begin
                state_q <= S_IDLE;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        if (start_i) begin
                            is_div_q <= op_i[1];
                            neg_q    <= sa ^ sb;
                            sign_a_q <= sa;
                            divz_q   <= op_i[1] & (src_b_i == '0);
                            opnd_q   <= op_i[1] ? abs_b : abs_a;
                            acc_q    <= {{WIDTH{1'b0}}, (op_i[1] ? abs_a : abs_b)};
                            cnt_q    <= '0;
                            state_q  <= S_CALC;
                        end else begin
                            if (hi_we_i) hi_q <= wdata_i;
                            if (lo_we_i) lo_q <= wdata_i;
                        end
                    end
                    S_CALC: begin
                        acc_q <= acc_d;
                        cnt_q <= cnt_q + CW'(1);
                        if (cnt_q == CW'(WIDTH - 1)) begin
                            hi_q    <= hi_d;
                            lo_q    <= lo_d;
                            done_q  <= 1'b1;
                            state_q <= S_DONE;
                        end
                    end
                    default: state_q <= S_IDLE;
                endcase
            end
        end
    end

    assign done_o = done_q;
    assign busy_o = (state_q != S_IDLE);
    assign hi_o   = hi_q;
    assign lo_o   = lo_q;

endmodule

// File: tb/tb_muldiv_sequencer.sv
module tb_muldiv_sequencer;
  localparam int W = 32;

  // clock / reset
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic         start_i, flush_i, hi_we_i, lo_we_i;
  logic [1:0]   op_i;
  logic [W-1:0] src_a_i, src_b_i, wdata_i;
  logic         stall_o, done_o, busy_o;
  logic [W-1:0] hi_o, lo_o;

  muldiv_sequencer #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .start_i(start_i), .op_i(op_i),
    .src_a_i(src_a_i), .src_b_i(src_b_i), .flush_i(flush_i),
    .hi_we_i(hi_we_i), .lo_we_i(lo_we_i), .wdata_i(wdata_i),
    .stall_o(stall_o), .done_o(done_o), .busy_o(busy_o),
    .hi_o(hi_o), .lo_o(lo_o)
  );

  localparam logic [1:0] OP_MULT = 2'b00, OP_MULTU = 2'b01, OP_DIV = 2'b10, OP_DIVU = 2'b11;

  int checks = 0;
  int errors = 0;
  logic [2*W-1:0] exp_q[$];

  task automatic chk(input string name, input logic [2*W-1:0] act, input logic [2*W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // scoreboard monitor: every done_o pulse pops one expected {hi,lo}
  always @(negedge clk) begin
    if (done_o === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_done: got hi=%h lo=%h expected no done_o", hi_o, lo_o);
      end else begin
        logic [2*W-1:0] e;
        e = exp_q.pop_front();
        if ({hi_o, lo_o} !== e) begin
          errors++;
          $display("FAIL result: got %h expected %h", {hi_o, lo_o}, e);
        end
      end
    end
  end

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // present an op, record its accept cycle, leave start_i held
  task automatic issue(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [2*W-1:0] exp, output int acc_cyc);
    start_i = 1'b1; op_i = op; src_a_i = a; src_b_i = b;
    exp_q.push_back(exp);
    @(negedge clk);
    chk("stall_accept", {63'b0, stall_o}, 64'd1);
    acc_cyc = cyc;
    step();
  endtask

  // wait (bounded) for done_o; stall must stay high until then and drop in DONE
  task automatic wait_done(output int dcyc);
    bit stall_bad = 1'b0;
    bit seen = 1'b0;
    int n = 0;
    dcyc = -1;
    while (!seen && n < 100) begin
      @(negedge clk);
      if (done_o === 1'b1) begin
        seen = 1'b1;
        dcyc = cyc;
      end else if (stall_o !== 1'b1) begin
        stall_bad = 1'b1;
      end
      n++;
    end
    if (!seen) begin
      checks++; errors++;
      $display("FAIL done_timeout: got no done_o expected done_o within 100 cycles");
    end else begin
      chk("stall_calc", {63'b0, stall_bad}, 64'd0);
      chk("stall_done", {63'b0, stall_o}, 64'd0);
    end
    step();
  endtask

  task automatic run_op(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [2*W-1:0] exp);
    int ac, dc;
    issue(op, a, b, exp, ac);
    wait_done(dc);
    start_i = 1'b0;
  endtask

  initial begin
    int ac, d1, d2, n;
    bit seen;
    reset = 1'b1; start_i = 0; flush_i = 0; hi_we_i = 0; lo_we_i = 0;
    op_i = 0; src_a_i = 0; src_b_i = 0; wdata_i = 0;
    repeat (3) step();
    @(negedge clk);
    chk("rst_hi", {32'b0, hi_o}, 64'd0);
    chk("rst_lo", {32'b0, lo_o}, 64'd0);
    chk("rst_busy", {63'b0, busy_o}, 64'd0);
    chk("rst_done", {63'b0, done_o}, 64'd0);
    chk("rst_stall", {63'b0, stall_o}, 64'd0);
    step();
    reset = 1'b0;
    step();

    // MTHI / MTLO
    hi_we_i = 1; wdata_i = 32'hAAAA_0001; step();
    hi_we_i = 0; lo_we_i = 1; wdata_i = 32'hBBBB_0002; step();
    lo_we_i = 0;
    @(negedge clk);
    chk("mthi", {32'b0, hi_o}, {32'b0, 32'hAAAA_0001});
    chk("mtlo", {32'b0, lo_o}, {32'b0, 32'hBBBB_0002});
    step();

    // MULTU max*max with latency
    issue(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, {32'hFFFF_FFFE, 32'h0000_0001}, ac);
    wait_done(d1);
    start_i = 1'b0;
    chk("latency", 64'(d1 - ac), 64'd33);
    step();

    run_op(OP_MULT,  32'hFFFF_FFFD, 32'd7,        {32'hFFFF_FFFF, 32'hFFFF_FFEB});
    run_op(OP_DIV,   32'hFFFF_FFF9, 32'd2,        {32'hFFFF_FFFF, 32'hFFFF_FFFD});
    run_op(OP_DIVU,  32'd5,         32'd0,        {32'h0000_0005, 32'hFFFF_FFFF});
    run_op(OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, {32'h0000_0000, 32'h8000_0000});
    run_op(OP_DIV,   32'hFFFF_FFF9, 32'd0,        {32'hFFFF_FFF9, 32'hFFFF_FFFF});
    run_op(OP_DIV,   32'd7,         32'hFFFF_FFFE, {32'h0000_0001, 32'hFFFF_FFFD});
    run_op(OP_MULT,  32'h8000_0000, 32'h8000_0000, {32'h4000_0000, 32'h0000_0000});
    run_op(OP_DIVU,  32'd100,       32'd7,        {32'h0000_0002, 32'h0000_000E});

    // MTHI then MULTU 2*3 flushed at cnt=10, then retried
    hi_we_i = 1; wdata_i = 32'h0000_1234; step();
    hi_we_i = 0;
    start_i = 1; op_i = OP_MULTU; src_a_i = 32'd2; src_b_i = 32'd3;
    step();                 // accepted; now CALC cnt=0
    repeat (10) step();     // CALC cnt=10
    flush_i = 1; start_i = 0;
    step();
    flush_i = 0;
    @(negedge clk);
    chk("flush_busy", {63'b0, busy_o}, 64'd0);
    chk("flush_hi", {32'b0, hi_o}, {32'b0, 32'h0000_1234});
    seen = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (done_o === 1'b1) seen = 1'b1;
    end
    chk("flush_no_done", {63'b0, seen}, 64'd0);
    step();
    run_op(OP_MULTU, 32'd2, 32'd3, {32'h0, 32'd6});

    // back-to-back MULTU with start held
    issue(OP_MULTU, 32'd3, 32'd4, {32'h0, 32'd12}, ac);
    exp_q.push_back({32'h0, 32'd12});
    wait_done(d1);
    wait_done(d2);
    start_i = 1'b0;
    chk("b2b_gap", 64'(d2 - d1), 64'd34);
    step();

    // reset mid-CALC
    start_i = 1; op_i = OP_MULTU; src_a_i = 32'd5; src_b_i = 32'd5;
    repeat (6) step();
    reset = 1; start_i = 0;
    step();
    @(negedge clk);
    chk("rstmid_hi", {32'b0, hi_o}, 64'd0);
    chk("rstmid_lo", {32'b0, lo_o}, 64'd0);
    chk("rstmid_busy", {63'b0, busy_o}, 64'd0);
    chk("rstmid_stall", {63'b0, stall_o}, 64'd0);
    step();
    reset = 0;
    step();

    // MTLO together with an accepted start: start wins
    lo_we_i = 1; wdata_i = 32'h0000_DEAD;
    issue(OP_MULTU, 32'd1, 32'd1, {32'h0, 32'd1}, ac);
    lo_we_i = 0;
    @(negedge clk);
    chk("mtlo_ignored", {32'b0, lo_o}, 64'd0);
    wait_done(d1);
    start_i = 1'b0;
    repeat (3) step();

    chk("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1, "watchdog");
  end
endmodule
